alu_share_arbiter: RTL

Shares one combinational ALU between two requesters (req0: execute stage, req1: branch/address unit) using a round-robin arbiter.
Each requester uses a valid/ready handshake to submit operands and an opcode.
The block registers the operands onto the ALU inputs, captures the ALU result and zero flag, and returns them tagged with the requester id over a valid/ready response channel.
It sits between the pipeline front-ends and the single ALU instance.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_share_arbiter_if.sv | 53 +++++
 rtl/rr_arbiter2.sv | 40 ++++
 rtl/alu_share_arbiter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU sharing arbiter: default widths,
// ALU opcode encodings, FSM state encoding and the counter saturation helper.
package alu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int OP_W_DEF   = 3;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_NOR  = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [2:0] ALU_SLTU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bundle of the two request channels, the ALU operand/result lines and the
// response channel. slave = the arbiter's view, master = the surrounding pipeline/ALU.
interface alu_share_arbiter_if #(
    parameter int DATA_W = alu_pkg::DATA_W_DEF,
    parameter int OP_W   = alu_pkg::OP_W_DEF
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [OP_W-1:0]   req0_op;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [OP_W-1:0]   req1_op;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_ctrl;
    logic [DATA_W-1:0] alu_y;
    logic              alu_z;

    logic              resp_valid;
    logic              resp_ready;
    logic              resp_id;
    logic [DATA_W-1:0] resp_y;
    logic              resp_z;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output alu_a, alu_b, alu_ctrl,
        input  alu_y, alu_z,
        output resp_valid, resp_id, resp_y, resp_z,
        input  resp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  alu_a, alu_b, alu_ctrl,
        output alu_y, alu_z,
        input  resp_valid, resp_id, resp_y, resp_z,
        output resp_ready
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic; purely combinational, the last-grant
// pointer is owned by the parent.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant,
    output logic       grant_id
);

    // Single requester wins outright; on contention the one not served last wins.
    always_comb begin
        grant    = 2'b00;
        grant_id = 1'b0;
        if (enable) begin
            case (req)
                2'b01: begin
                    grant    = 2'b01;
                    grant_id = 1'b0;
                end
                2'b10: begin
                    grant    = 2'b10;
                    grant_id = 1'b1;
                end
                2'b11: begin
                    grant    = last_grant ? 2'b01 : 2'b10;
                    grant_id = ~last_grant;
                end
                default: begin
                    grant    = 2'b00;
                    grant_id = 1'b0;
                end
            endcase
        end else begin
            grant    = 2'b00;
            grant_id = 1'b0;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters (IDLE -> EXEC -> RESP).
// Optional per-requester grant counters are built when ALU_ARB_PERF_EN is defined.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
`ifdef ALU_ARB_PERF_EN
    output logic [15:0] grant_cnt0,
    output logic [15:0] grant_cnt1,
`endif
    alu_share_arbiter_if.slave bus
);

    state_t            state_r;
    state_t            state_nx_s;
    logic              last_grant_r;
    logic [1:0]        grant_s;
    logic              grant_id_s;
    logic              arb_en_s;
    logic              accept_s;

    logic [DATA_W-1:0] alu_a_r;
    logic [DATA_W-1:0] alu_b_r;
    logic [OP_W-1:0]   alu_ctrl_r;
    logic              resp_valid_r;
    logic              resp_id_r;
    logic [DATA_W-1:0] resp_y_r;
    logic              resp_z_r;

    // Grants are only offered in IDLE and never while reset is held.
    assign arb_en_s = (state_r == ST_IDLE) && !rst;

    rr_arbiter2 u_arb (
        .req        ({bus.req1_valid, bus.req0_valid}),
        .last_grant (last_grant_r),
        .enable     (arb_en_s),
        .grant      (grant_s),
        .grant_id   (grant_id_s)
    );

    assign accept_s       = |grant_s;
    assign bus.req0_ready = grant_s[0];
    assign bus.req1_ready = grant_s[1];

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = ST_EXEC;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_nx_s = ST_RESP;
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RESP;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, operand and result registers; alu_* and resp_* hold until the next accept/capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
            alu_a_r      <= '0;
            alu_b_r      <= '0;
            alu_ctrl_r   <= '0;
            resp_valid_r <= 1'b0;
            resp_id_r    <= 1'b0;
            resp_y_r     <= '0;
            resp_z_r     <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            resp_valid_r <= (state_nx_s == ST_RESP);
            if (accept_s) begin
                alu_a_r      <= grant_id_s ? bus.req1_a  : bus.req0_a;
                alu_b_r      <= grant_id_s ? bus.req1_b  : bus.req0_b;
                alu_ctrl_r   <= grant_id_s ? bus.req1_op : bus.req0_op;
                resp_id_r    <= grant_id_s;
                last_grant_r <= grant_id_s;
            end
            if (state_r == ST_EXEC) begin
                resp_y_r <= bus.alu_y;
                resp_z_r <= bus.alu_z;
            end
        end
    end

    assign bus.alu_a      = alu_a_r;
    assign bus.alu_b      = alu_b_r;
    assign bus.alu_ctrl   = alu_ctrl_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_id    = resp_id_r;
    assign bus.resp_y     = resp_y_r;
    assign bus.resp_z     = resp_z_r;

`ifdef ALU_ARB_PERF_EN
    logic [15:0] cnt0_r;
    logic [15:0] cnt1_r;

    // Saturating count of accepted handshakes per requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_r <= 16'd0;
            cnt1_r <= 16'd0;
        end else begin
            if (accept_s && !grant_id_s) begin
                cnt0_r <= sat_inc16(cnt0_r);
            end
            if (accept_s && grant_id_s) begin
                cnt1_r <= sat_inc16(cnt1_r);
            end
        end
    end

    assign grant_cnt0 = cnt0_r;
    assign grant_cnt1 = cnt1_r;
`endif

endmodule
